// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: latches two WIDTH-bit operands and feeds them LSB-first
// through a 1-bit XOR / NAND-NAND full adder. The carry is held in a flop between bits.

module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;
    logic nand_ab;
    logic nand_pc;

    assign p       = a ^ b;
    assign s       = p ^ ci;
    // Carry as NAND-NAND: co = (a&b) | (p&ci)
    assign nand_ab = ~(a & b);
    assign nand_pc = ~(p & ci);
    assign co      = ~(nand_ab & nand_pc);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic fa_s;
    logic fa_co;
    logic last_bit;

    serial_adder_fa u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt_q == CNT_LAST);

    // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would
    // make the result depend on statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start)    state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // busy/done are decoded from the next state and registered, so they are glitch-free
    // and line up with the state they describe.
    always_comb begin
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // NOTE: the operand, sum and carry registers are plain flops, not a memory, so they
    // all take the async reset and the aborted operation leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = fa_s;
                carry_d          = fa_co;
                if (last_bit) begin
                    cout_d = fa_co;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 scoreboard run plus a WIDTH=1 instance.

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    logic [8:0] exp_q[$];
    logic [8:0] exp_pop;
    logic       prev_cout;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: every done pulse pops one expected {cout,sum}.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_pop = exp_q.pop_front();
                check("sum", {24'd0, sum}, {24'd0, exp_pop[7:0]});
                check("cout", {31'd0, cout}, {31'd0, exp_pop[8]});
            end
        end
    end

    // Accept in cycle 0, busy in cycles 1..8, done in cycle 9. Inputs are scrambled after
    // acceptance; with hold=1 start stays high through SHIFT and DONE.
    task automatic do_op(input logic [7:0] a_v, input logic [7:0] b_v, input logic c_v,
                         input bit hold);
        logic [8:0] e;
        e = {1'b0, a_v} + {1'b0, b_v} + {8'd0, c_v};
        @(negedge clk);
        a = a_v; b = b_v; cin = c_v; start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        check("clr_sum", {24'd0, sum}, 32'd0);
        check("cout_hold", {31'd0, cout}, {31'd0, prev_cout});
        start = hold;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) @(negedge clk);
            check("busy", {31'd0, busy}, 32'd1);
            check("done_low", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_off", {31'd0, busy}, 32'd0);
        prev_cout = e[8];
    endtask

    task automatic do_op1(input logic a_v, input logic b_v, input logic c_v);
        logic [1:0] e;
        e = {1'b0, a_v} + {1'b0, b_v} + {1'b0, c_v};
        @(negedge clk);
        a1 = a_v; b1 = b_v; cin1 = c_v; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("w1_busy", {31'd0, busy1}, 32'd1);
        check("w1_done_low", {31'd0, done1}, 32'd0);
        @(negedge clk);
        check("w1_done", {31'd0, done1}, 32'd1);
        check("w1_sum", {31'd0, sum1}, {31'd0, e[0]});
        check("w1_cout", {31'd0, cout1}, {31'd0, e[1]});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        prev_cout = 1'b0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op(8'h00, 8'h00, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'hA5, 8'h5A, 1'b1, 1'b0);
        do_op(8'h3C, 8'h0F, 1'b0, 1'b0);

        // Idle: results hold, nothing pulses.
        repeat (3) begin
            @(negedge clk);
            check("idle_sum", {24'd0, sum}, 32'h4B);
            check("idle_busy", {31'd0, busy}, 32'd0);
        end

        // Back-to-back with start held high: one op every 10 cycles.
        do_op(8'h81, 8'h7F, 1'b0, 1'b1);
        do_op(8'h55, 8'h22, 1'b1, 1'b1);
        do_op(8'hF0, 8'hF0, 1'b1, 1'b1);
        start = 1'b0;

        // Reset in cycle 4 of SHIFT after a cout=1 result.
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        prev_cout = 1'b0;
        do_op(8'h12, 8'h34, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            do_op1(k[2], k[1], k[0]);
        end

        for (int n = 0; n < 1000; n++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
